// File: rtl/peri_pkg.sv
// Shared definitions for the peripheral-link blocks: receiver state encoding,
// idle levels of the link lines and a constant-evaluable clog2.
package peri_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_LONG = 2'd2
  } rx_state_e;

  localparam logic IDLE_CLK  = 1'b0;
  localparam logic IDLE_DATA = 1'b0;
  localparam logic IDLE_CS   = 1'b1;

  function automatic int unsigned peri_clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one link line followed by a one-flop edge detector.
// Edges are suppressed until the chain holds only post-reset samples.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic [STAGES:0]   r_fill;
  logic              w_armed;

  // Synchronizer chain, edge-history flop and post-reset fill tracker
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
      r_fill <= {r_fill[STAGES-1:0], 1'b1};
    end
  end

  // A line held at a non-idle level through reset must not look like an edge.
  assign w_armed = r_fill[STAGES];
  assign o_level = r_sync[STAGES-1];
  assign o_rise  = w_armed & r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = w_armed & ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/peri_serial_rx.sv
// Receiver for the bit-banged peripheral link: synchronizes P_CLOCK/P_DATA/P_CS,
// shifts in MSB-first frames and hands complete words over a valid/ack register.
module peri_serial_rx
  import peri_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s_clk,
  input  logic             s_data,
  input  logic             s_cs,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ack,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int             CW   = peri_clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic w_clk_level, w_clk_rise, w_clk_fall;
  logic w_data_level, w_data_rise, w_data_fall;
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_unused;

  rx_state_e        r_state, w_next_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_word;
  logic             r_valid, r_ferr, r_overrun;
  logic             w_clear, w_shift, w_load, w_ferr;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(IDLE_CLK)) u_sync_clk (
    .clock(clock), .reset(reset), .i_d(s_clk),
    .o_level(w_clk_level), .o_rise(w_clk_rise), .o_fall(w_clk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(IDLE_DATA)) u_sync_data (
    .clock(clock), .reset(reset), .i_d(s_data),
    .o_level(w_data_level), .o_rise(w_data_rise), .o_fall(w_data_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(IDLE_CS)) u_sync_cs (
    .clock(clock), .reset(reset), .i_d(s_cs),
    .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  assign w_unused = &{1'b0, w_clk_level, w_clk_fall, w_data_rise, w_data_fall, w_cs_level};

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and datapath controls; a cs edge always wins over a coincident clock edge
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_shift      = 1'b0;
    w_load       = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_next_state = ST_RECV;
          w_clear      = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (w_cs_rise) begin
          w_next_state = ST_IDLE;
          if (r_count == FULL) begin
            w_load = 1'b1;
          end else begin
            w_ferr = 1'b1;
          end
        end else if (w_clk_rise) begin
          if (r_count == FULL) begin
            w_next_state = ST_LONG;
          end else begin
            w_shift = 1'b1;
          end
        end else begin
          w_next_state = ST_RECV;
        end
      end
      ST_LONG: begin
        if (w_cs_rise) begin
          w_next_state = ST_IDLE;
          w_ferr       = 1'b1;
        end else begin
          w_next_state = ST_LONG;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Shift register and bit counter; the counter never passes FULL since shifting stops there
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (w_clear) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (w_shift) begin
      r_shift <= {r_shift[WIDTH-2:0], w_data_level};
      r_count <= r_count + CW'(1);
    end else begin
      r_shift <= r_shift;
      r_count <= r_count;
    end
  end

  // Output holding register with valid/ack handshake and sticky overrun
  always_ff @(posedge clock) begin
    if (reset) begin
      r_word    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      if (w_load) begin
        r_word  <= r_shift;
        r_valid <= 1'b1;
        if (r_valid && !word_ack) begin
          r_overrun <= 1'b1;
        end else begin
          r_overrun <= r_overrun;
        end
      end else if (r_valid && word_ack) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

  assign word_out   = r_word;
  assign word_valid = r_valid;
  assign frame_err  = r_ferr;
  assign overrun    = r_overrun;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_peri_serial_rx.sv
// Self-checking bench for peri_serial_rx: a table of frames, directed corner
// sequences and random frames, all checked against a word-level model.
module tb_peri_serial_rx;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset, s_clk, s_data, s_cs, word_ack;
  logic [W-1:0] word_out;
  logic         word_valid, frame_err, overrun, busy;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] m_word;
  logic         m_valid, m_ovr;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    bit          ack_load;
    bit          ack_after;
    bit          rst_before;
  } vec_t;

  vec_t vecs [8];

  peri_serial_rx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .s_clk(s_clk), .s_data(s_data), .s_cs(s_cs),
    .word_out(word_out), .word_valid(word_valid), .word_ack(word_ack),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; s_cs = 1'b1; s_clk = 1'b0; s_data = 1'b0; word_ack = 1'b0;
    tick(3);
    reset = 1'b0;
    m_word = '0; m_valid = 1'b0; m_ovr = 1'b0;
    tick(4);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".word"},    32'(word_out),   32'(m_word));
    check({tag, ".valid"},   32'(word_valid), 32'(m_valid));
    check({tag, ".overrun"}, 32'(overrun),    32'(m_ovr));
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) begin
      s_data = bits[i];
      s_clk  = 1'b0;
      tick(half);
      s_clk  = 1'b1;
      tick(half);
    end
    s_clk = 1'b0;
    tick(half);
  endtask

  // Raise cs and check the close-of-frame edge exactly three edges later.
  task automatic close_and_check(input bit ack_in_load, input int nbits,
                                 input logic [31:0] bits, input string tag);
    bit exp_ferr;
    s_cs = 1'b1;
    tick(2);
    check({tag, ".ferr_early"}, 32'(frame_err), 32'd0);
    check({tag, ".valid_early"}, 32'(word_valid), 32'(m_valid));
    word_ack = ack_in_load;
    tick(1);
    word_ack = 1'b0;
    exp_ferr = (nbits != W);
    if (!exp_ferr) begin
      if (m_valid && !ack_in_load) m_ovr = 1'b1;
      m_word  = bits[W-1:0];
      m_valid = 1'b1;
    end else if (ack_in_load && m_valid) begin
      m_valid = 1'b0;
    end
    check({tag, ".ferr"}, 32'(frame_err), 32'(exp_ferr));
    check({tag, ".busy_end"}, 32'(busy), 32'd0);
    check_outputs(tag);
    tick(1);
    check({tag, ".ferr_pulse"}, 32'(frame_err), 32'd0);
    tick(1);
  endtask

  task automatic run_frame(input logic [31:0] bits, input int n, input int half,
                           input bit ack_in_load, input string tag);
    s_cs = 1'b0;
    tick(half);
    shift_bits(bits, n, half);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    close_and_check(ack_in_load, n, bits, tag);
  endtask

  task automatic do_ack(input string tag);
    word_ack = 1'b1;
    tick(1);
    word_ack = 1'b0;
    m_valid = 1'b0;
    check({tag, ".ack_valid"}, 32'(word_valid), 32'(m_valid));
  endtask

  initial begin
    vecs[0] = '{32'h0000A5C3, 16, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h00007ABC, 15, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h0001ABCD, 17, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h00001234, 16, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h0000BEEF, 16, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h00001234, 16, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{32'h0000BEEF, 16, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{32'h00000000, 0,  1'b0, 1'b0, 1'b0};

    do_reset();
    check("reset.ferr", 32'(frame_err), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check_outputs("reset");

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].rst_before) do_reset();
      run_frame(vecs[v].bits, vecs[v].nbits, 4, vecs[v].ack_load, $sformatf("vec%0d", v));
      if (vecs[v].ack_after) do_ack($sformatf("vec%0d", v));
    end

    // Empty frame: busy must show while cs is low even with no clocks.
    s_cs = 1'b0;
    tick(2);
    check("empty.busy_pre", 32'(busy), 32'd0);
    tick(1);
    check("empty.busy", 32'(busy), 32'd1);
    close_and_check(1'b0, 0, 32'd0, "empty");

    // cs rise coincident with the 16th clock rise closes the frame at 15 bits.
    s_cs = 1'b0;
    tick(4);
    shift_bits(32'h0000C3A5 >> 1, 15, 4);
    s_data = 1'b1;
    tick(2);
    s_clk = 1'b1;
    close_and_check(1'b0, 15, 32'd0, "coinc");
    s_clk = 1'b0;
    tick(2);

    // Reset mid-frame with cs held low: the following clocks must be ignored.
    s_cs = 1'b0;
    tick(4);
    shift_bits(32'h000000AB, 8, 2);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    m_word = '0; m_valid = 1'b0; m_ovr = 1'b0;
    shift_bits(32'h0000FFFF, 16, 2);
    check("rstmid.busy", 32'(busy), 32'd0);
    s_cs = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick(1);
      check("rstmid.ferr", 32'(frame_err), 32'd0);
    end
    check_outputs("rstmid");
    run_frame(32'h000000FF, 16, 2, 1'b0, "after_rst");

    // Random frames against the model.
    do_reset();
    for (int r = 0; r < 24; r++) begin
      int          n;
      logic [31:0] bits;
      n = ($urandom_range(0, 2) != 0) ? W : int'($urandom_range(13, 18));
      bits = $urandom;
      run_frame(bits, n, int'($urandom_range(2, 4)), 1'($urandom_range(0, 1)),
                $sformatf("rnd%0d", r));
      if ($urandom_range(0, 1) == 1) do_ack($sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
